// File: rtl/seg7_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_pkg
// Shared types and helpers for the 7-segment scan controller.
//   state_t : scan FSM states (IDLE, SHOW, GAP)
//   BCD_W   : width of one BCD nibble
//   onehot  : index -> one-hot anode pattern, MAX_DIGITS wide; callers
//             size-cast the result down to their own digit count
// -----------------------------------------------------------------------------
package seg7_scan_pkg;

   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
      logic [MAX_DIGITS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// -----------------------------------------------------------------------------
// seg7_scan_timer
// Down-counter that times the dwell and gap slots. Loading N-1 makes done
// assert N cycles later, so the owning FSM sees a slot of exactly N cycles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force the count to 0 (scan parked)
//   load      : load load_val (slot start); clear has priority
//   load_val  : slot length minus one
//   done      : count has reached 0 (last cycle of the slot)
// -----------------------------------------------------------------------------
module seg7_scan_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         // Stops at zero; the FSM always reloads before the next slot.
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a NUM_DIGITS 7-segment display sharing
// one BCD decoder. Each digit is lit for DWELL_CYC clocks, then all anodes go
// dark for GAP_CYC clocks. Loads are double-buffered in a shadow register and
// committed only at frame start, so a frame never mixes old and new values.
// Optional feature: define SEG7_SCAN_LZB_EN for leading-zero blanking
// (digit 0 is never blanked).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   enable      : 1 = scan runs, 0 = dark and parked at digit 0
//   load_valid  : load_data valid
//   load_ready  : shadow register free (no load pending)
//   load_data   : packed BCD nibbles, [3:0] = digit 0 (rightmost)
//   bcd_out     : nibble for the shared decoder (registered)
//   digit_an    : one-hot active-high anode enables (registered)
//   digit_idx   : currently selected digit
//   frame_done  : 1-cycle pulse, registered on the edge that ends the last
//                 gap of a frame (coincides with digit 0 of the next frame)
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
   import seg7_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL_CYC  = 50000,
   parameter int GAP_CYC    = 500
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic [4*NUM_DIGITS-1:0]       load_data,
   output logic [3:0]                    bcd_out,
   output logic [NUM_DIGITS-1:0]         digit_an,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_done
);

   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int MAX_CYC = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   state_t                   state, state_nx;
   logic [IDX_W-1:0]         idx_nx;
   logic [BCD_W*NUM_DIGITS-1:0] display, shadow, disp_nx;
   logic                     pending;
   logic                     accept, commit;
   logic                     tmr_clear, tmr_load, tmr_done;
   logic [TMR_W-1:0]         tmr_val;
   logic                     frame_done_nx;
   logic [NUM_DIGITS-1:0]    blank, an_nx;
   logic [3:0]               bcd_nx;

   assign load_ready = !pending;
   assign accept     = load_valid && load_ready;

   seg7_scan_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clear),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // NOTE: every output of this block gets a default before the case, so no
   // path can leave a value unassigned and infer a latch.
   always_comb begin
      state_nx      = state;
      idx_nx        = digit_idx;
      commit        = 1'b0;
      tmr_clear     = 1'b0;
      tmr_load      = 1'b0;
      tmr_val       = DWELL_LD;
      frame_done_nx = 1'b0;
      if (!enable) begin
         state_nx  = IDLE;
         idx_nx    = '0;
         tmr_clear = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_nx = SHOW;
               idx_nx   = '0;
               tmr_load = 1'b1;
               commit   = pending;
            end
            SHOW: begin
               if (tmr_done) begin
                  state_nx = GAP;
                  tmr_load = 1'b1;
                  tmr_val  = GAP_LD;
               end
            end
            GAP: begin
               if (tmr_done) begin
                  state_nx = SHOW;
                  tmr_load = 1'b1;
                  if (digit_idx == LAST_IDX) begin
                     idx_nx        = '0;
                     frame_done_nx = 1'b1;
                     commit        = pending;
                  end else begin
                     idx_nx = digit_idx + IDX_W'(1);
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Outputs are computed from next-state values so anode and nibble switch
   // on the same edge; a commit feeds the shadow value straight through.
   assign disp_nx = commit ? shadow : display;

`ifdef SEG7_SCAN_LZB_EN
   // A digit is blanked when it and every higher digit are zero.
   always_comb begin
      logic run;
      run   = 1'b1;
      blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         run      = run && (disp_nx[i*BCD_W +: BCD_W] == '0);
         blank[i] = run;
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      an_nx  = '0;
      bcd_nx = bcd_out;
      if (state_nx == SHOW) begin
         an_nx  = NUM_DIGITS'(onehot(3'(idx_nx))) & ~blank;
         bcd_nx = disp_nx[idx_nx*BCD_W +: BCD_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         digit_idx  <= '0;
         // NOTE: display and shadow are reset so the first frame after reset
         // shows 0000 and a load cut short by reset is discarded.
         display    <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         bcd_out    <= '0;
         digit_an   <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         digit_idx  <= idx_nx;
         display    <= disp_nx;
         bcd_out    <= bcd_nx;
         digit_an   <= an_nx;
         frame_done <= frame_done_nx;
         // load_ready is low while pending, so accept and commit never
         // coincide and the shadow cannot change under a commit.
         if (commit) begin
            pending <= 1'b0;
         end else if (accept) begin
            shadow  <= load_data;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit 7-segment display that shares one BCD-to-7-segment decoder across all digits. Each frame it steps through the digits: it presents one BCD nibble to the shared decoder, enables that digit's anode, then blanks all anodes for a short gap to prevent ghosting. New display values arrive over a valid/ready handshake. They are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new values.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DWELL_CYC, 50000, clocks each digit is lit (>=1)
GAP_CYC, 500, clocks all anodes are off between digits (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = scanning runs; 0 = display dark, FSM parked
load_valid  in  1  load_data is valid
load_ready  out  1  block can accept a load
load_data  in  4*NUM_DIGITS  BCD nibbles; [3:0] = digit 0 (rightmost)
bcd_out  out  4  nibble driven to the shared decoder
digit_an  out  NUM_DIGITS  one-hot anode enable, active-high
digit_idx  out  $clog2(NUM_DIGITS)  index of the digit currently selected
frame_done  out  1  1-cycle pulse at the end of each frame's last gap

Behaviour:
- Reset, sampled on the clk edge, sets the following: state IDLE; the display and shadow registers to all 4'h0; pending=0; the timer to 0; bcd_out=0; digit_an=0; digit_idx=0; frame_done=0; load_ready=1.
- Load handshake: a load is accepted when load_valid && load_ready are both high on a clk edge. The accepted value goes into the shadow register and pending is set to 1.
- load_ready = !pending.
- Commit: when pending=1 and the FSM enters SHOW for digit 0 (frame start), the shadow register is copied to the display register and pending is cleared. load_ready therefore rises in the cycle after the commit.
- FSM states:
  - IDLE: digit_an=0. Moves to SHOW (digit 0, timer=0, commit if pending) when enable=1.
  - SHOW: digit_an = one-hot(digit_idx) and bcd_out = display nibble[digit_idx]. When timer == DWELL_CYC-1, moves to GAP with timer=0.
  - GAP: digit_an=0 and bcd_out holds its value. When timer == GAP_CYC-1:
    - if digit_idx == NUM_DIGITS-1: digit_idx=0, frame_done=1 for that cycle, go to SHOW (commit if pending);
    - otherwise: digit_idx += 1 and go to SHOW.
- Outputs are registered. digit_an and bcd_out change on the same edge, so the new nibble is never lit under the old anode.
- enable=0 in any state: on the next edge go to IDLE, set digit_an=0, digit_idx=0, timer=0. Any pending load stays pending. Re-enabling always starts a frame at digit 0.
- A load arriving in the same cycle as a frame-start commit is refused, because load_ready=0 while pending. This means a new load can never overwrite the shadow register while a commit is happening.
- Nibbles above 4'h9 are passed through unchanged; the shared decoder renders them as its error pattern.
- Timer width is $clog2(max(DWELL_CYC, GAP_CYC)). The timer wraps only through the explicit compare; there is no free-run overflow.
- Frame period = NUM_DIGITS*(DWELL_CYC+GAP_CYC) clocks.

Optional Feature:
Macro SEG7_SCAN_LZB_EN enables leading-zero blanking.
- Defined: a digit is a leading zero when its nibble is 0 and all higher digits are also 0. During SHOW for such a digit, digit_an stays 0. Digit 0 is never blanked, so a value of 0000 displays "0". The slot timing is unchanged.
- Undefined: every digit is lit in its slot.

Decomposition:
- Package seg7_scan_pkg:
  - state enum {IDLE, SHOW, GAP};
  - the constant BCD_W=4;
  - a function onehot(idx) returning NUM_DIGITS bits.
- Sub-module seg7_scan_timer: the dwell/gap down-counter with a load value and a done output. The FSM, shadow/commit logic and LZB logic stay in the top module.

Test Plan:
(Bench parameters: NUM_DIGITS=4, DWELL_CYC=4, GAP_CYC=2 for all scenarios.)
1. Reset/scan order: rst for 3 cycles, enable=1, load 16'h4321 → digit_an sequence 0001,0000,0010,0000,0100,0000,1000,0000 with 4/2-cycle spacing; bcd_out=1,2,3,4 in each slot; frame_done pulses once every 24 cycles.
2. Tear-free update: load 16'h9999 during the digit-2 slot → the current frame still shows 4321; the next frame shows 9999; load_ready is 0 from the accept until the cycle after the frame-start commit.
3. Back-pressure: hold load_valid=1 with 16'h5555 then 16'h6666 → only 5555 is accepted before the commit; 6666 is accepted after load_ready rises and is displayed one frame later.
4. Enable drop mid-digit: deassert enable during SHOW of digit 2 → digit_an=0 on the next edge; re-enable → scanning restarts at digit 0 with the timer at 0.
5. Reset mid-operation: assert rst during GAP with pending=1 → all outputs return to reset values, pending is cleared, and the display shows 0000 after re-enable.
6. LZB (macro defined): load 16'h0070 → digit 3 is dark, digit 2 is dark, digit 1 shows 7, digit 0 shows 0; load 16'h0000 → only digit 0 is lit.
